// File: rtl/frost32_mem_arbiter_if.sv
// Bundle of the two requester ports and the external memory port around the arbiter.
// Carries no logic of its own; timing is set by the arbiter.
// The master view belongs to the arbiter, the slave view to requesters and memory.
interface frost32_mem_arbiter_if;
    // instruction fetch requester
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_ack;
    logic [31:0] fetch_rdata;
    logic        fetch_err;

    // data-access requester
    logic        data_req;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_access_type;
    logic [1:0]  data_access_size;
    logic        data_ack;
    logic [31:0] data_rdata;
    logic        data_err;

    // shared external memory port
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_access_type;
    logic [1:0]  mem_access_size;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        input  fetch_req, fetch_addr,
        output fetch_ack, fetch_rdata, fetch_err,
        input  data_req, data_addr, data_wdata, data_access_type, data_access_size,
        output data_ack, data_rdata, data_err,
        output mem_req, mem_addr, mem_wdata, mem_access_type, mem_access_size,
        input  mem_ack, mem_rdata
    );

    modport slave (
        output fetch_req, fetch_addr,
        input  fetch_ack, fetch_rdata, fetch_err,
        output data_req, data_addr, data_wdata, data_access_type, data_access_size,
        input  data_ack, data_rdata, data_err,
        input  mem_req, mem_addr, mem_wdata, mem_access_type, mem_access_size,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/frost32_mem_arbiter.sv
// Arbitrates one external memory port between instruction fetch and data access.
// Latency: request to mem_req 1 cycle, mem_ack to requester ack 1 cycle, 3 cycles minimum per access.
// Backpressure: requesters hold req until their one-cycle ack; memory stalls by withholding mem_ack.
module frost32_mem_arbiter #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int FAIR_ARB       = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    frost32_mem_arbiter_if.master bus
);

    // counter only needs to reach TIMEOUT_CYCLES-1
    localparam int               CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam bit               TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [1:0]       SIZE_BAD   = 2'd3;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFetch = 2'd1,
        StData  = 2'd2,
        StAck   = 2'd3
    } state_t;

    typedef enum logic {
        GrantFetch = 1'b0,
        GrantData  = 1'b1
    } grant_t;

    state_t           state_q,       state_nxt;
    grant_t           last_grant_q,  last_grant_nxt;
    logic [CNT_W-1:0] cnt_q,         cnt_nxt;

    logic             fetch_ack_q,   fetch_ack_nxt;
    logic [31:0]      fetch_rdata_q, fetch_rdata_nxt;
    logic             fetch_err_q,   fetch_err_nxt;
    logic             data_ack_q,    data_ack_nxt;
    logic [31:0]      data_rdata_q,  data_rdata_nxt;
    logic             data_err_q,    data_err_nxt;

    logic             mem_req_q,     mem_req_nxt;
    logic [31:0]      mem_addr_q,    mem_addr_nxt;
    logic [31:0]      mem_wdata_q,   mem_wdata_nxt;
    logic             mem_type_q,    mem_type_nxt;
    logic [1:0]       mem_size_q,    mem_size_nxt;

    logic             grant_data;
    logic             grant_fetch;
    logic             timeout_hit;

    // pick a winner among pending requests; data wins ties unless round-robin is enabled
    always_comb begin
        grant_data  = 1'b0;
        grant_fetch = 1'b0;
        if (bus.data_req && bus.fetch_req) begin
            if ((FAIR_ARB != 0) && (last_grant_q == GrantData)) begin
                grant_fetch = 1'b1;
            end else begin
                grant_data = 1'b1;
            end
        end else if (bus.data_req) begin
            grant_data = 1'b1;
        end else if (bus.fetch_req) begin
            grant_fetch = 1'b1;
        end
    end

    // memory has stalled too long; a same-cycle mem_ack takes priority over this
    assign timeout_hit = TIMEOUT_EN && (cnt_q == CNT_LAST);

    // next-state and next-output logic; acks and errors default low so they pulse for one cycle
    always_comb begin
        state_nxt       = state_q;
        last_grant_nxt  = last_grant_q;
        cnt_nxt         = cnt_q;
        fetch_ack_nxt   = 1'b0;
        fetch_err_nxt   = 1'b0;
        fetch_rdata_nxt = fetch_rdata_q;
        data_ack_nxt    = 1'b0;
        data_err_nxt    = 1'b0;
        data_rdata_nxt  = data_rdata_q;
        mem_req_nxt     = mem_req_q;
        mem_addr_nxt    = mem_addr_q;
        mem_wdata_nxt   = mem_wdata_q;
        mem_type_nxt    = mem_type_q;
        mem_size_nxt    = mem_size_q;

        case (state_q)
            StIdle: begin
                cnt_nxt = '0;
                if (grant_data) begin
                    last_grant_nxt = GrantData;
                    if (bus.data_access_size == SIZE_BAD) begin
                        // rejected locally, memory never sees it
                        data_ack_nxt   = 1'b1;
                        data_err_nxt   = 1'b1;
                        data_rdata_nxt = '0;
                        state_nxt      = StAck;
                    end else begin
                        mem_req_nxt   = 1'b1;
                        mem_addr_nxt  = bus.data_addr;
                        mem_wdata_nxt = bus.data_wdata;
                        mem_type_nxt  = bus.data_access_type;
                        mem_size_nxt  = bus.data_access_size;
                        state_nxt     = StData;
                    end
                end else if (grant_fetch) begin
                    last_grant_nxt = GrantFetch;
                    mem_req_nxt    = 1'b1;
                    mem_addr_nxt   = bus.fetch_addr;
                    mem_wdata_nxt  = '0;
                    mem_type_nxt   = 1'b0;
                    mem_size_nxt   = 2'd0;
                    state_nxt      = StFetch;
                end
            end

            StFetch: begin
                if (bus.mem_ack) begin
                    mem_req_nxt     = 1'b0;
                    fetch_ack_nxt   = 1'b1;
                    fetch_rdata_nxt = bus.mem_rdata;
                    state_nxt       = StAck;
                end else if (timeout_hit) begin
                    mem_req_nxt     = 1'b0;
                    fetch_ack_nxt   = 1'b1;
                    fetch_err_nxt   = 1'b1;
                    fetch_rdata_nxt = '0;
                    state_nxt       = StAck;
                end else begin
                    cnt_nxt = cnt_q + CNT_W'(1);
                end
            end

            StData: begin
                if (bus.mem_ack) begin
                    mem_req_nxt    = 1'b0;
                    data_ack_nxt   = 1'b1;
                    // writes return no data
                    data_rdata_nxt = mem_type_q ? 32'd0 : bus.mem_rdata;
                    state_nxt      = StAck;
                end else if (timeout_hit) begin
                    mem_req_nxt    = 1'b0;
                    data_ack_nxt   = 1'b1;
                    data_err_nxt   = 1'b1;
                    data_rdata_nxt = '0;
                    state_nxt      = StAck;
                end else begin
                    cnt_nxt = cnt_q + CNT_W'(1);
                end
            end

            StAck: begin
                // requests are ignored here; the requester drops req while it sees ack
                cnt_nxt   = '0;
                state_nxt = StIdle;
            end

            default: begin
                state_nxt   = StIdle;
                mem_req_nxt = 1'b0;
                cnt_nxt     = '0;
            end
        endcase
    end

    // state and output registers; reset abandons any in-flight access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            last_grant_q  <= GrantFetch;
            cnt_q         <= '0;
            fetch_ack_q   <= 1'b0;
            fetch_rdata_q <= '0;
            fetch_err_q   <= 1'b0;
            data_ack_q    <= 1'b0;
            data_rdata_q  <= '0;
            data_err_q    <= 1'b0;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            mem_type_q    <= 1'b0;
            mem_size_q    <= 2'd0;
        end else begin
            state_q       <= state_nxt;
            last_grant_q  <= last_grant_nxt;
            cnt_q         <= cnt_nxt;
            fetch_ack_q   <= fetch_ack_nxt;
            fetch_rdata_q <= fetch_rdata_nxt;
            fetch_err_q   <= fetch_err_nxt;
            data_ack_q    <= data_ack_nxt;
            data_rdata_q  <= data_rdata_nxt;
            data_err_q    <= data_err_nxt;
            mem_req_q     <= mem_req_nxt;
            mem_addr_q    <= mem_addr_nxt;
            mem_wdata_q   <= mem_wdata_nxt;
            mem_type_q    <= mem_type_nxt;
            mem_size_q    <= mem_size_nxt;
        end
    end

    assign bus.fetch_ack       = fetch_ack_q;
    assign bus.fetch_rdata     = fetch_rdata_q;
    assign bus.fetch_err       = fetch_err_q;
    assign bus.data_ack        = data_ack_q;
    assign bus.data_rdata      = data_rdata_q;
    assign bus.data_err        = data_err_q;
    assign bus.mem_req         = mem_req_q;
    assign bus.mem_addr        = mem_addr_q;
    assign bus.mem_wdata       = mem_wdata_q;
    assign bus.mem_access_type = mem_type_q;
    assign bus.mem_access_size = mem_size_q;

    // only one requester can ever be completing
    assert property (@(posedge clk) disable iff (!rst_n) !(fetch_ack_q && data_ack_q));

    // the memory-side attributes never change under an outstanding request
    assert property (@(posedge clk) disable iff (!rst_n)
        (mem_req_q && $past(mem_req_q)) |-> ($stable(mem_addr_q) && $stable(mem_wdata_q)
                                            && $stable(mem_type_q) && $stable(mem_size_q)));

endmodule

// File: tb/tb_frost32_mem_arbiter.sv
// Bench for frost32_mem_arbiter: vector table, hand sequences and random traffic vs a reference model.
// Runs a priority instance and a round-robin instance, both with a 4-cycle memory timeout.
// Requesters drop req on ack; the memory model acks after a chosen number of mem_req cycles.
module tb_frost32_mem_arbiter;

    localparam int T     = 4;
    localparam int NEVER = 99;
    localparam int NV    = 10;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    frost32_mem_arbiter_if mi ();
    frost32_mem_arbiter_if fi ();

    frost32_mem_arbiter #(.TIMEOUT_CYCLES(T), .FAIR_ARB(0)) u_dut  (.clk(clk), .rst_n(rst_n), .bus(mi));
    frost32_mem_arbiter #(.TIMEOUT_CYCLES(T), .FAIR_ARB(1)) u_fair (.clk(clk), .rst_n(rst_n), .bus(fi));

    int checks = 0;
    int errors = 0;

    // current transaction stimulus
    bit          c_fon, c_don;
    logic [31:0] c_faddr, c_daddr, c_wdata;
    logic        c_wr;
    logic [1:0]  c_size;
    int          c_dly [2];
    logic [31:0] c_rd  [2];

    // observed results
    int          o_fack_n, o_dack_n, o_fack_cnt, o_dack_cnt, o_eps, o_unstable;
    logic [31:0] o_frdata, o_drdata;
    logic        o_ferr, o_derr;
    logic [31:0] o_addr [2];
    logic [31:0] o_wdata[2];
    logic        o_type [2];
    logic [1:0]  o_size [2];
    int          o_len  [2];

    // expected results (ack cycle -1 means no ack expected)
    int          e_fack_n, e_dack_n, e_eps;
    logic [31:0] e_frdata, e_drdata;
    logic        e_ferr, e_derr;
    logic [31:0] e_addr [2];
    logic [31:0] e_wdata[2];
    logic        e_type [2];
    logic [1:0]  e_size [2];
    int          e_len  [2];

    typedef struct {
        bit          is_data;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        wr;
        logic [1:0]  size;
        int          dly;
        logic [31:0] rd;
        int          exp_n;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_len;
        logic        exp_type;
        logic [1:0]  exp_size;
    } vec_t;

    vec_t tbl [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag);
        chk({tag, ".mem_req"},     32'(mi.mem_req), 32'd0);
        chk({tag, ".mem_addr"},    mi.mem_addr, 32'd0);
        chk({tag, ".mem_wdata"},   mi.mem_wdata, 32'd0);
        chk({tag, ".fetch_rdata"}, mi.fetch_rdata, 32'd0);
        chk({tag, ".data_rdata"},  mi.data_rdata, 32'd0);
        chk({tag, ".flags"}, 32'({mi.mem_access_type, mi.mem_access_size, mi.fetch_ack,
                                  mi.fetch_err, mi.data_ack, mi.data_err}), 32'd0);
    endtask

    // drive one request (or a simultaneous pair), play the memory, collect what comes back
    task automatic run_txn();
        int n, ep, k, last;
        bit prev, done;
        o_fack_n = -1; o_dack_n = -1; o_fack_cnt = 0; o_dack_cnt = 0;
        o_eps = 0; o_unstable = 0; o_frdata = '0; o_drdata = '0; o_ferr = 0; o_derr = 0;
        for (int i = 0; i < 2; i++) o_len[i] = 0;
        mi.fetch_req        = c_fon;
        mi.fetch_addr       = c_faddr;
        mi.data_req         = c_don;
        mi.data_addr        = c_daddr;
        mi.data_wdata       = c_wdata;
        mi.data_access_type = c_wr;
        mi.data_access_size = c_size;
        n = 0; ep = -1; k = 0; prev = 0; done = 0;
        while (!done && n < 60) begin
            @(posedge clk); #1;
            n++;
            if (mi.fetch_ack) begin
                o_fack_cnt++;
                if (o_fack_n < 0) begin
                    o_fack_n = n; o_frdata = mi.fetch_rdata; o_ferr = mi.fetch_err;
                end
                mi.fetch_req = 1'b0;
            end
            if (mi.data_ack) begin
                o_dack_cnt++;
                if (o_dack_n < 0) begin
                    o_dack_n = n; o_drdata = mi.data_rdata; o_derr = mi.data_err;
                end
                mi.data_req = 1'b0;
            end
            if (mi.mem_req) begin
                if (!prev) begin
                    o_eps++; ep++; k = 0;
                    if (ep < 2) begin
                        o_addr[ep] = mi.mem_addr; o_wdata[ep] = mi.mem_wdata;
                        o_type[ep] = mi.mem_access_type; o_size[ep] = mi.mem_access_size;
                    end
                end else begin
                    k++;
                    if (ep < 2 && (mi.mem_addr !== o_addr[ep] || mi.mem_wdata !== o_wdata[ep] ||
                                   mi.mem_access_type !== o_type[ep] || mi.mem_access_size !== o_size[ep]))
                        o_unstable++;
                end
                if (ep < 2) o_len[ep]++;
                mi.mem_ack   = (ep < 2) && (k == c_dly[ep < 2 ? ep : 0]);
                mi.mem_rdata = (ep < 2) ? c_rd[ep] : 32'd0;
            end else begin
                // stray acks while nothing is outstanding must be ignored
                mi.mem_ack   = 1'($urandom_range(0, 1));
                mi.mem_rdata = $urandom;
            end
            prev = mi.mem_req;
            last = (o_fack_n > o_dack_n) ? o_fack_n : o_dack_n;
            done = (!c_fon || o_fack_n >= 0) && (!c_don || o_dack_n >= 0) && (n >= last + 3);
        end
        mi.fetch_req = 1'b0;
        mi.data_req  = 1'b0;
        mi.mem_ack   = 1'b0;
    endtask

    // reference: data before fetch on a tie; each access is judged on its own ack delay
    task automatic model();
        int t, ep, ackn;
        bit is_d;
        logic [31:0] rd;
        logic err;
        t = 0; ep = 0; e_fack_n = -1; e_dack_n = -1;
        for (int pass = 0; pass < 2; pass++) begin
            is_d = (pass == 0);
            if (is_d ? !c_don : !c_fon) continue;
            if (is_d && c_size == 2'd3) begin
                ackn = t + 1; rd = '0; err = 1'b1;
            end else begin
                e_addr[ep]  = is_d ? c_daddr : c_faddr;
                e_type[ep]  = is_d & c_wr;
                e_size[ep]  = is_d ? c_size : 2'd0;
                e_wdata[ep] = c_wdata;
                if (c_dly[ep] < T) begin
                    ackn = t + c_dly[ep] + 2; err = 1'b0;
                    rd = (is_d && c_wr) ? 32'd0 : c_rd[ep];
                    e_len[ep] = c_dly[ep] + 1;
                end else begin
                    ackn = t + T + 1; err = 1'b1; rd = '0; e_len[ep] = T;
                end
                ep++;
            end
            if (is_d) begin e_dack_n = ackn; e_drdata = rd; e_derr = err; end
            else      begin e_fack_n = ackn; e_frdata = rd; e_ferr = err; end
            t = ackn + 1;
        end
        e_eps = ep;
    endtask

    task automatic compare(input string tag);
        chk({tag, ".fack_cnt"}, 32'(o_fack_cnt), (e_fack_n >= 0) ? 32'd1 : 32'd0);
        chk({tag, ".dack_cnt"}, 32'(o_dack_cnt), (e_dack_n >= 0) ? 32'd1 : 32'd0);
        if (e_fack_n >= 0) begin
            chk({tag, ".fack_cycle"}, 32'(o_fack_n), 32'(e_fack_n));
            chk({tag, ".fetch_rdata"}, o_frdata, e_frdata);
            chk({tag, ".fetch_err"}, 32'(o_ferr), 32'(e_ferr));
        end
        if (e_dack_n >= 0) begin
            chk({tag, ".dack_cycle"}, 32'(o_dack_n), 32'(e_dack_n));
            chk({tag, ".data_rdata"}, o_drdata, e_drdata);
            chk({tag, ".data_err"}, 32'(o_derr), 32'(e_derr));
        end
        chk({tag, ".mem_episodes"}, 32'(o_eps), 32'(e_eps));
        for (int i = 0; i < e_eps && i < 2 && i < o_eps; i++) begin
            chk($sformatf("%s.mem_addr%0d", tag, i), o_addr[i], e_addr[i]);
            chk($sformatf("%s.mem_type%0d", tag, i), 32'(o_type[i]), 32'(e_type[i]));
            chk($sformatf("%s.mem_size%0d", tag, i), 32'(o_size[i]), 32'(e_size[i]));
            chk($sformatf("%s.mem_req_len%0d", tag, i), 32'(o_len[i]), 32'(e_len[i]));
            if (e_type[i]) chk($sformatf("%s.mem_wdata%0d", tag, i), o_wdata[i], e_wdata[i]);
        end
        chk({tag, ".mem_unstable"}, 32'(o_unstable), 32'd0);
    endtask

    initial begin
        int got[$];
        int cyc, mode;
        bit seen_req, first_is_data, first_seen;

        //          data addr          wdata          wr    size  dly    rd             n  rdata          err   len type size
        tbl[0] = '{1'b0, 32'h0000_0100, 32'h0,         1'b0, 2'd0, 0,     32'hDEADBEEF, 2, 32'hDEADBEEF, 1'b0, 1, 1'b0, 2'd0};
        tbl[1] = '{1'b1, 32'h0000_0040, 32'h0,         1'b0, 2'd0, 1,     32'hCAFEF00D, 3, 32'hCAFEF00D, 1'b0, 2, 1'b0, 2'd0};
        tbl[2] = '{1'b1, 32'h0000_0300, 32'h1234_5678, 1'b1, 2'd2, 0,     32'h55AA55AA, 2, 32'h0,        1'b0, 1, 1'b1, 2'd2};
        tbl[3] = '{1'b1, 32'h0000_0042, 32'h0,         1'b0, 2'd1, 2,     32'h0000BEEF, 4, 32'h0000BEEF, 1'b0, 3, 1'b0, 2'd1};
        tbl[4] = '{1'b1, 32'h0000_0044, 32'h0,         1'b0, 2'd3, 0,     32'h11111111, 1, 32'h0,        1'b1, 0, 1'b0, 2'd0};
        tbl[5] = '{1'b0, 32'h0000_0104, 32'h0,         1'b0, 2'd0, NEVER, 32'h22222222, 5, 32'h0,        1'b1, 4, 1'b0, 2'd0};
        tbl[6] = '{1'b1, 32'h0000_0048, 32'h0,         1'b0, 2'd0, 3,     32'h0A0B0C0D, 5, 32'h0A0B0C0D, 1'b0, 4, 1'b0, 2'd0};
        tbl[7] = '{1'b1, 32'h0000_004C, 32'hFFFF0000,  1'b1, 2'd3, 0,     32'h33333333, 1, 32'h0,        1'b1, 0, 1'b0, 2'd0};
        tbl[8] = '{1'b1, 32'h0000_0050, 32'hA5A5A5A5,  1'b1, 2'd1, NEVER, 32'h44444444, 5, 32'h0,        1'b1, 4, 1'b1, 2'd1};
        tbl[9] = '{1'b0, 32'h0000_0108, 32'h0,         1'b0, 2'd0, 3,     32'h11112222, 5, 32'h11112222, 1'b0, 4, 1'b0, 2'd0};

        rst_n = 1'b0;
        mi.fetch_req = 0; mi.fetch_addr = 0; mi.data_req = 0; mi.data_addr = 0; mi.data_wdata = 0;
        mi.data_access_type = 0; mi.data_access_size = 0; mi.mem_ack = 0; mi.mem_rdata = 0;
        fi.fetch_req = 0; fi.fetch_addr = 0; fi.data_req = 0; fi.data_addr = 0; fi.data_wdata = 0;
        fi.data_access_type = 0; fi.data_access_size = 0; fi.mem_ack = 0; fi.mem_rdata = 0;

        repeat (3) @(posedge clk);
        #1;
        chk_outs("reset");
        chk("reset.fair_outs", 32'({fi.mem_req, fi.fetch_ack, fi.data_ack}), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // vector table, one requester at a time
        for (int i = 0; i < NV; i++) begin
            c_fon = !tbl[i].is_data; c_don = tbl[i].is_data;
            c_faddr = tbl[i].addr; c_daddr = tbl[i].addr; c_wdata = tbl[i].wdata;
            c_wr = tbl[i].wr; c_size = tbl[i].size;
            c_dly[0] = tbl[i].dly; c_dly[1] = NEVER; c_rd[0] = tbl[i].rd; c_rd[1] = '0;
            e_fack_n = tbl[i].is_data ? -1 : tbl[i].exp_n;
            e_dack_n = tbl[i].is_data ? tbl[i].exp_n : -1;
            e_frdata = tbl[i].exp_rdata; e_drdata = tbl[i].exp_rdata;
            e_ferr = tbl[i].exp_err; e_derr = tbl[i].exp_err;
            e_eps = (tbl[i].exp_len > 0) ? 1 : 0;
            e_addr[0] = tbl[i].addr; e_wdata[0] = tbl[i].wdata;
            e_type[0] = tbl[i].exp_type; e_size[0] = tbl[i].exp_size; e_len[0] = tbl[i].exp_len;
            run_txn();
            compare($sformatf("vec%0d", i));
        end

        // simultaneous fetch and data write: data first, then fetch
        c_fon = 1; c_don = 1; c_faddr = 32'h200; c_daddr = 32'h300; c_wdata = 32'h1234_5678;
        c_wr = 1; c_size = 2'd2; c_dly[0] = 0; c_dly[1] = 0; c_rd[0] = 32'hAAAA0001; c_rd[1] = 32'hBBBB0002;
        e_dack_n = 2; e_drdata = 32'h0; e_derr = 0;
        e_fack_n = 5; e_frdata = 32'hBBBB0002; e_ferr = 0;
        e_eps = 2;
        e_addr[0] = 32'h300; e_type[0] = 1; e_size[0] = 2'd2; e_wdata[0] = 32'h1234_5678; e_len[0] = 1;
        e_addr[1] = 32'h200; e_type[1] = 0; e_size[1] = 2'd0; e_wdata[1] = 32'h0;        e_len[1] = 1;
        run_txn();
        compare("tie");

        // stray mem_ack with nothing outstanding
        mi.mem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("idle_ack.mem_req", 32'(mi.mem_req), 32'd0);
            chk("idle_ack.acks", 32'({mi.fetch_ack, mi.data_ack}), 32'd0);
        end
        mi.mem_ack = 1'b0;

        // random traffic against the reference model
        for (int r = 0; r < 40; r++) begin
            mode = $urandom_range(1, 3);
            c_fon = mode[0]; c_don = mode[1];
            c_faddr = $urandom; c_daddr = $urandom; c_wdata = $urandom;
            c_wr = 1'($urandom_range(0, 1)); c_size = 2'($urandom_range(0, 3));
            for (int i = 0; i < 2; i++) begin
                c_dly[i] = $urandom_range(0, 6);
                c_rd[i]  = $urandom;
            end
            model();
            run_txn();
            compare($sformatf("rnd%0d", r));
        end

        // reset in the middle of a data access
        mi.data_req = 1; mi.data_addr = 32'h500; mi.data_access_type = 0; mi.data_access_size = 2'd0;
        mi.mem_ack = 0;
        @(posedge clk); #1;
        chk("rst.mem_req_before", 32'(mi.mem_req), 32'd1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk_outs("rst.mid");
        mi.data_req = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        c_fon = 1; c_don = 0; c_faddr = 32'h600; c_dly[0] = 0; c_dly[1] = NEVER;
        c_rd[0] = 32'h600D600D; c_rd[1] = '0;
        model();
        run_txn();
        compare("post_rst");

        // round-robin instance: both requesting continuously alternates, data first
        fi.data_addr = 32'hD000; fi.fetch_addr = 32'hF000; fi.data_access_size = 2'd0;
        fi.data_access_type = 0; fi.fetch_req = 1; fi.data_req = 1;
        cyc = 0;
        while (got.size() < 6 && cyc < 80) begin
            @(posedge clk); #1;
            cyc++;
            if (fi.data_ack)  got.push_back(1);
            if (fi.fetch_ack) got.push_back(0);
            fi.mem_ack = fi.mem_req;
        end
        fi.fetch_req = 0; fi.data_req = 0; fi.mem_ack = 0;
        chk("fair.grant_count", 32'(got.size()), 32'd6);
        for (int i = 0; i < got.size(); i++)
            chk($sformatf("fair.grant%0d_is_data", i), 32'(got[i]), (i % 2 == 0) ? 32'd1 : 32'd0);
        @(posedge clk); #1;

        // bad-size reject still counts as a data grant for round-robin
        fi.data_access_size = 2'd3; fi.data_req = 1;
        cyc = 0; seen_req = 0;
        while (!fi.data_ack && cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
            if (fi.mem_req) seen_req = 1;
        end
        chk("fair.bad_ack_cycle", 32'(cyc), 32'd1);
        chk("fair.bad_err", 32'(fi.data_err), 32'd1);
        chk("fair.bad_rdata", fi.data_rdata, 32'd0);
        chk("fair.bad_mem_req", 32'(seen_req), 32'd0);
        fi.data_req = 0;
        @(posedge clk); #1;
        fi.data_access_size = 2'd0; fi.data_req = 1; fi.fetch_req = 1;
        cyc = 0; first_seen = 0; first_is_data = 0;
        while (!first_seen && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
            if (fi.data_ack || fi.fetch_ack) begin
                first_seen = 1; first_is_data = fi.data_ack;
            end
            fi.mem_ack = fi.mem_req;
        end
        fi.data_req = 0; fi.fetch_req = 0; fi.mem_ack = 0;
        chk("fair.after_reject_seen", 32'(first_seen), 32'd1);
        chk("fair.after_reject_is_data", 32'(first_is_data), 32'd0);
        repeat (3) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
